// File: rtl/sap_pkg.sv
// sap_pkg: shared definitions for the SAP controller-sequencer.
//   - opcode constants (anything not listed decodes as NOP)
//   - one-hot T-state encodings T1..T6 and the HALT encoding
//   - control-word struct and its inactive value
//   - helper functions for opcode classification and last T-state
// Optional feature macro used by users of this package: SEQ_VARIABLE_CYCLE_EN
package sap_pkg;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  localparam logic [5:0] T1     = 6'b000001;
  localparam logic [5:0] T2     = 6'b000010;
  localparam logic [5:0] T3     = 6'b000100;
  localparam logic [5:0] T4     = 6'b001000;
  localparam logic [5:0] T5     = 6'b010000;
  localparam logic [5:0] T6     = 6'b100000;
  localparam logic [5:0] T_HALT = 6'b000000;

  // Run/halt state of the sequencer.
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } run_state_e;

  // Control word, polarities as seen on the pins (_n = active low).
  typedef struct packed {
    logic cp;
    logic ep;
    logic lm_n;
    logic ce_n;
    logic li_n;
    logic ei_n;
    logic la_n;
    logic ea;
    logic su;
    logic eu;
    logic lb_n;
    logic lo_n;
  } ctrl_word_t;

  localparam ctrl_word_t CTRL_INACTIVE = '{
    cp: 1'b0, ep: 1'b0, lm_n: 1'b1, ce_n: 1'b1, li_n: 1'b1, ei_n: 1'b1,
    la_n: 1'b1, ea: 1'b0, su: 1'b0, eu: 1'b0, lb_n: 1'b1, lo_n: 1'b1
  };

  // ADD and SUB share the same execute sequence apart from Su.
  function automatic logic is_arith(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

  // Last T-state that carries any active control for an opcode. HLT keeps
  // the full ring since it leaves through HALT entry at T4 anyway.
  function automatic logic [5:0] last_tstate(input logic [3:0] op);
    logic [5:0] t;
    case (op)
      OP_LDA:         t = T5;
      OP_OUT:         t = T4;
      OP_ADD, OP_SUB: t = T6;
      OP_HLT:         t = T6;
      default:        t = T3;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/ring_counter.sv
// ring_counter: one-hot 6-stage T-state ring.
// Ports:
//   clk  in  1  system clock
//   rst  in  1  synchronous reset, active high -> T1
//   clr  in  1  early return to T1 on the next edge
//   hold in  1  freeze the ring (machine halted)
//   ring out 6  one-hot state, bit0 = T1
// Priority: rst > hold > clr > advance.
module ring_counter
  import sap_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       hold,
  output logic [5:0] ring
);

  logic [5:0] ring_reg;
  logic [5:0] ring_next;

  always_comb begin
    ring_next = {ring_reg[4:0], ring_reg[5]};
    if (hold) begin
      ring_next = ring_reg;
    end else if (clr) begin
      ring_next = T1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ring_reg <= T1;
    end else begin
      ring_reg <= ring_next;
    end
  end

  assign ring = ring_reg;

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: SAP controller-sequencer. Steps the one-hot T-state
// ring through fetch (T1..T3) and execute (T4..T6) and decodes the control
// word from the current T-state and the opcode held by the IR (Moore).
// Ports:
//   clk, rst (sync, active high), instruction[3:0]
//   Cp, Ep, Ea, Su, Eu, hlt       active high
//   Lm, CE, Li, Ei, La, Lb, Lo    active low
//   t_state[5:0]                  one-hot T1..T6, 0 when halted
// Optional feature: SEQ_VARIABLE_CYCLE_EN -- when defined, the ring returns
// to T1 right after the last T-state that does any work for the opcode.
module control_sequencer
  import sap_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] instruction,
  output logic       Cp,
  output logic       Ep,
  output logic       Lm,
  output logic       CE,
  output logic       Li,
  output logic       Ei,
  output logic       La,
  output logic       Ea,
  output logic       Su,
  output logic       Eu,
  output logic       Lb,
  output logic       Lo,
  output logic       hlt,
  output logic [5:0] t_state
);

  run_state_e state_reg;
  run_state_e state_next;
  logic [5:0] ring;
  logic       enter_halt;
  logic       clr;
  ctrl_word_t cw;

  // HLT is recognised in T4, once the IR holds the new opcode.
  assign enter_halt = (state_reg == ST_RUN) && (ring == T4) && (instruction == OP_HLT);

  always_comb begin
    state_next = state_reg;
    if (enter_halt) begin
      state_next = ST_HALT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_RUN;
    end else begin
      state_reg <= state_next;
    end
  end

`ifdef SEQ_VARIABLE_CYCLE_EN
  // T6 wraps on its own; only shorter instructions need the early clear.
  assign clr = (ring == last_tstate(instruction)) && (ring != T6);
`else
  assign clr = 1'b0;
`endif

  // Freeze the ring on the HALT entry edge too, so it never runs past T4.
  ring_counter u_ring (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .hold ((state_reg == ST_HALT) || enter_halt),
    .ring (ring)
  );

  always_comb begin
    cw = CTRL_INACTIVE;
    if (!rst && (state_reg == ST_RUN)) begin
      case (ring)
        T1: begin
          cw.ep   = 1'b1;
          cw.lm_n = 1'b0;
        end
        T2: begin
          cw.cp = 1'b1;
        end
        T3: begin
          cw.ce_n = 1'b0;
          cw.li_n = 1'b0;
        end
        T4: begin
          if ((instruction == OP_LDA) || is_arith(instruction)) begin
            cw.lm_n = 1'b0;
            cw.ei_n = 1'b0;
          end else if (instruction == OP_OUT) begin
            cw.ea   = 1'b1;
            cw.lo_n = 1'b0;
          end
        end
        T5: begin
          if (instruction == OP_LDA) begin
            cw.ce_n = 1'b0;
            cw.la_n = 1'b0;
          end else if (is_arith(instruction)) begin
            cw.ce_n = 1'b0;
            cw.lb_n = 1'b0;
          end
        end
        T6: begin
          if (is_arith(instruction)) begin
            cw.la_n = 1'b0;
            cw.eu   = 1'b1;
            cw.su   = (instruction == OP_SUB);
          end
        end
        default: cw = CTRL_INACTIVE;
      endcase
    end
  end

  assign Cp      = cw.cp;
  assign Ep      = cw.ep;
  assign Lm      = cw.lm_n;
  assign CE      = cw.ce_n;
  assign Li      = cw.li_n;
  assign Ei      = cw.ei_n;
  assign La      = cw.la_n;
  assign Ea      = cw.ea;
  assign Su      = cw.su;
  assign Eu      = cw.eu;
  assign Lb      = cw.lb_n;
  assign Lo      = cw.lo_n;
  assign hlt     = (state_reg == ST_HALT) && !rst;
  assign t_state = (state_reg == ST_HALT) ? T_HALT : ring;

endmodule
